// File: rtl/pol_win_sched.sv
// Address-window scheduler for the pooling crossbar: steps [AddrMin, AddrMax) across the job range.
// Optional macro POL_WS_WRAP_EN: the window wraps back to the start base until every core is done.
module pol_win_sched #(
  parameter int POOL_CORE  = 6,
  parameter int IDX_WIDTH  = 10,
  parameter int OUT_MAX    = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           CCUWS_Start,
  input  logic [IDX_WIDTH-1:0]           CCUWS_AddrBase,
  input  logic [IDX_WIDTH-1:0]           CCUWS_AddrEnd,
  input  logic [IDX_WIDTH-1:0]           CCUWS_WinSize,
  input  logic [POOL_CORE-1:0]           POLWS_AddrVld,
  input  logic [IDX_WIDTH*POOL_CORE-1:0] POLWS_Addr,
  input  logic [POOL_CORE-1:0]           POLWS_CoreDone,
  input  logic                           MICWS_CmdPush,
  input  logic                           MICWS_OfmPop,
  output logic                           WSMIC_Rst,
  output logic [IDX_WIDTH-1:0]           WSMIC_AddrMin,
  output logic [IDX_WIDTH-1:0]           WSMIC_AddrMax,
  output logic                           WSCCU_Busy,
  output logic                           WSCCU_Done,
  output logic                           WSCCU_Err
);

  localparam int OW = $clog2(OUT_MAX + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [OW-1:0] OUT_MAX_C     = OW'(OUT_MAX);
  localparam logic [SW-1:0] SETTLE_LAST_C = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_ADV  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] base_q, base_d;
  logic [IDX_WIDTH-1:0] end_q, end_d;
  logic [IDX_WIDTH-1:0] ws_q, ws_d;
  logic [IDX_WIDTH-1:0] min_q, min_d;
  logic [IDX_WIDTH-1:0] max_q, max_d;
  logic [OW-1:0]        out_q, out_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic                 rst_q, rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef POL_WS_WRAP_EN
  logic [IDX_WIDTH-1:0] base0_q, base0_d;
`endif

  logic [POOL_CORE-1:0] hit_s;
  logic                 all_done_s;
  logic                 idle_s;
  logic [IDX_WIDTH:0]   nb_s;

  // Window upper bound, clipped to the range end; the sum is one bit wider so it cannot wrap.
  function automatic logic [IDX_WIDTH-1:0] win_max(input logic [IDX_WIDTH-1:0] b,
                                                   input logic [IDX_WIDTH-1:0] w,
                                                   input logic [IDX_WIDTH-1:0] e);
    logic [IDX_WIDTH:0] sum;
    sum = {1'b0, b} + {1'b0, w};
    if ((w == {IDX_WIDTH{1'b0}}) || (sum > {1'b0, e})) begin
      win_max = e;
    end else begin
      win_max = sum[IDX_WIDTH-1:0];
    end
  endfunction

  for (genvar g = 0; g < POOL_CORE; g++) begin : g_hit
    assign hit_s[g] = POLWS_AddrVld[g]
                    && (POLWS_Addr[g*IDX_WIDTH +: IDX_WIDTH] >= min_q)
                    && (POLWS_Addr[g*IDX_WIDTH +: IDX_WIDTH] <  max_q);
  end

  assign all_done_s = &POLWS_CoreDone;
  assign idle_s     = !(|hit_s) && (out_q == {OW{1'b0}}) && !MICWS_CmdPush;
  assign nb_s       = (ws_q == {IDX_WIDTH{1'b0}}) ? {1'b0, end_q}
                                                  : ({1'b0, base_q} + {1'b0, ws_q});

  // Next-state, window bounds, outstanding/settle counters and output pulses
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    end_d    = end_q;
    ws_d     = ws_q;
    min_d    = min_q;
    max_d    = max_q;
    out_d    = out_q;
    settle_d = {SW{1'b0}};
    rst_d    = 1'b0;
    err_d    = err_q;
`ifdef POL_WS_WRAP_EN
    base0_d  = base0_q;
`endif

    // Outstanding reads are only tracked once the crossbar has been cleared for this job
    if ((state_q == ST_RUN) || (state_q == ST_ADV) || (state_q == ST_DONE)) begin
      case ({MICWS_CmdPush, MICWS_OfmPop})
        2'b10: begin
          if (out_q == OUT_MAX_C) begin
            err_d = 1'b1;
          end else begin
            out_d = out_q + OW'(1);
          end
        end
        2'b01: begin
          if (out_q == {OW{1'b0}}) begin
            err_d = 1'b1;
          end else begin
            out_d = out_q - OW'(1);
          end
        end
        default: out_d = out_q;
      endcase
    end else begin
      out_d = out_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (CCUWS_Start) begin
          state_d = ST_CLR;
          base_d  = CCUWS_AddrBase;
          end_d   = CCUWS_AddrEnd;
          ws_d    = CCUWS_WinSize;
          min_d   = CCUWS_AddrBase;
          max_d   = win_max(CCUWS_AddrBase, CCUWS_WinSize, CCUWS_AddrEnd);
          rst_d   = 1'b1;
          err_d   = 1'b0;
          out_d   = {OW{1'b0}};
`ifdef POL_WS_WRAP_EN
          base0_d = CCUWS_AddrBase;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        out_d = {OW{1'b0}};
        if (base_q >= end_q) begin
          state_d = ST_DONE;
          min_d   = {IDX_WIDTH{1'b0}};
          max_d   = {IDX_WIDTH{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (all_done_s && (out_q == {OW{1'b0}})) begin
          state_d = ST_DONE;
          min_d   = {IDX_WIDTH{1'b0}};
          max_d   = {IDX_WIDTH{1'b0}};
        end else if (idle_s && (settle_q == SETTLE_LAST_C)) begin
          state_d = ST_ADV;
        end else if (idle_s) begin
          settle_d = settle_q + SW'(1);
        end else begin
          settle_d = {SW{1'b0}};
        end
      end
      ST_ADV: begin
        if (nb_s >= {1'b0, end_q}) begin
`ifdef POL_WS_WRAP_EN
          if (!all_done_s) begin
            state_d = ST_RUN;
            base_d  = base0_q;
            min_d   = base0_q;
            max_d   = win_max(base0_q, ws_q, end_q);
          end else begin
            state_d = ST_DONE;
            min_d   = {IDX_WIDTH{1'b0}};
            max_d   = {IDX_WIDTH{1'b0}};
          end
`else
          state_d = ST_DONE;
          min_d   = {IDX_WIDTH{1'b0}};
          max_d   = {IDX_WIDTH{1'b0}};
`endif
        end else begin
          state_d = ST_RUN;
          base_d  = nb_s[IDX_WIDTH-1:0];
          min_d   = nb_s[IDX_WIDTH-1:0];
          max_d   = win_max(nb_s[IDX_WIDTH-1:0], ws_q, end_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        min_d   = {IDX_WIDTH{1'b0}};
        max_d   = {IDX_WIDTH{1'b0}};
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, job configuration and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= {IDX_WIDTH{1'b0}};
      end_q    <= {IDX_WIDTH{1'b0}};
      ws_q     <= {IDX_WIDTH{1'b0}};
      min_q    <= {IDX_WIDTH{1'b0}};
      max_q    <= {IDX_WIDTH{1'b0}};
      out_q    <= {OW{1'b0}};
      settle_q <= {SW{1'b0}};
      rst_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef POL_WS_WRAP_EN
      base0_q  <= {IDX_WIDTH{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      end_q    <= end_d;
      ws_q     <= ws_d;
      min_q    <= min_d;
      max_q    <= max_d;
      out_q    <= out_d;
      settle_q <= settle_d;
      rst_q    <= rst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef POL_WS_WRAP_EN
      base0_q  <= base0_d;
`endif
    end
  end

  assign WSMIC_Rst     = rst_q;
  assign WSMIC_AddrMin = min_q;
  assign WSMIC_AddrMax = max_q;
  assign WSCCU_Busy    = busy_q;
  assign WSCCU_Done    = done_q;
  assign WSCCU_Err     = err_q;

endmodule

// File: tb/tb_pol_win_sched.sv
// Directed self-checking bench for pol_win_sched; expectations cover both builds of POL_WS_WRAP_EN.
module tb_pol_win_sched;

  localparam int NC = 6;
  localparam int IW = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] base, aend, ws;
  logic [NC-1:0] vld;
  logic [IW*NC-1:0] addr;
  logic [NC-1:0] core_done;
  logic          push, pop;
  logic          o_rst, o_busy, o_done, o_err;
  logic [IW-1:0] o_min, o_max;

  int n_chk;
  int n_pass;

  pol_win_sched #(.POOL_CORE(NC), .IDX_WIDTH(IW), .OUT_MAX(8), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .CCUWS_Start(start), .CCUWS_AddrBase(base),
    .CCUWS_AddrEnd(aend), .CCUWS_WinSize(ws), .POLWS_AddrVld(vld), .POLWS_Addr(addr),
    .POLWS_CoreDone(core_done), .MICWS_CmdPush(push), .MICWS_OfmPop(pop),
    .WSMIC_Rst(o_rst), .WSMIC_AddrMin(o_min), .WSMIC_AddrMax(o_max),
    .WSCCU_Busy(o_busy), .WSCCU_Done(o_done), .WSCCU_Err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%06h expected 0x%06h ({rst,busy,done,err,min,max})", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic r, input logic b, input logic d, input logic e,
                                     input logic [IW-1:0] mn, input logic [IW-1:0] mx);
    pk = {8'd0, r, b, d, e, mn, mx};
  endfunction

  function automatic logic [31:0] obs();
    obs = pk(o_rst, o_busy, o_done, o_err, o_min, o_max);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_job(input logic [IW-1:0] b, input logic [IW-1:0] e, input logic [IW-1:0] w);
    base  = b;
    aend  = e;
    ws    = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [IW-1:0] t1_min [4];
  logic [IW-1:0] t1_max [4];

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; base = 10'd0; aend = 10'd0; ws = 10'd0;
    vld = 6'd0; addr = 60'd0; core_done = 6'd0; push = 1'b0; pop = 1'b0;
    t1_min = '{10'd0, 10'd32, 10'd64, 10'd96};
    t1_max = '{10'd32, 10'd64, 10'd96, 10'd100};
    cyc(2);
    check_eq("reset", obs(), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Windows and clip: four windows, each 2 RUN + 1 ADV cycles
    start_job(10'd0, 10'd100, 10'd32);
    check_eq("t1_clr", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd32));
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        check_eq($sformatf("t1_w%0d_c%0d", k, j), obs(),
                 pk(1'b0, 1'b1, 1'b0, 1'b0, t1_min[k], t1_max[k]));
      end
    end
    cyc(1);
`ifdef POL_WS_WRAP_EN
    check_eq("t1_wrap", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd32));
    core_done = 6'h3F;
    cyc(1);
`endif
    check_eq("t1_done", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0));
    core_done = 6'd0;
    cyc(1);
    check_eq("t1_idle", obs(), 32'd0);

    // Blocking request on core 3 plus one in-flight read
    start_job(10'd0, 10'd100, 10'd32);
    check_eq("t2_clr", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd32));
    addr[3*IW +: IW] = 10'd20;
    vld = 6'b001000;
    for (int c = 2; c <= 13; c++) begin
      cyc(1);
      push = (c == 2);
      pop  = (c == 7);
      vld  = (c < 11) ? 6'b001000 : 6'b000000;
      check_eq($sformatf("t2_hold_c%0d", c), obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd32));
    end
    push = 1'b0; pop = 1'b0;
    cyc(1);
    check_eq("t2_adv", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd32, 10'd64));
    core_done = 6'h3F;
    cyc(1);
    check_eq("t2_done", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0));
    core_done = 6'd0;
    cyc(1);
    check_eq("t2_idle", obs(), 32'd0);

    // Out-of-window request does not block; early finish with two reads outstanding
    start_job(10'd0, 10'd100, 10'd32);
    addr[3*IW +: IW] = 10'd40;
    vld = 6'b001000;
    cyc(3);
    check_eq("t3_nblk_adv", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd32));
    cyc(1);
    check_eq("t3_nblk_win", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd32, 10'd64));
    vld = 6'd0; push = 1'b1;
    cyc(2);
    push = 1'b0; core_done = 6'h3F;
    cyc(1);
    check_eq("t3_out2", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd32, 10'd64));
    pop = 1'b1;
    cyc(2);
    pop = 1'b0;
    check_eq("t3_out0", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd32, 10'd64));
    cyc(1);
    check_eq("t3_done", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0));
    core_done = 6'd0;
    cyc(1);
    check_eq("t3_idle", obs(), 32'd0);

    // Degenerate empty range
    start_job(10'd50, 10'd50, 10'd32);
    check_eq("t4_clr", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 10'd50, 10'd50));
    cyc(1);
    check_eq("t4_done", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0));
    cyc(1);
    check_eq("t4_idle", obs(), 32'd0);

    // Underflow sets a sticky error
    start_job(10'd0, 10'd100, 10'd32);
    cyc(1);
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    check_eq("t5_err", obs(), pk(1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 10'd32));
    core_done = 6'h3F;
    cyc(1);
    check_eq("t5_done", obs(), pk(1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0));
    core_done = 6'd0;
    cyc(3);
    check_eq("t5_sticky", obs(), pk(1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0));

    // Start clears Err; then asynchronous reset in the middle of window [32,64)
    start_job(10'd0, 10'd100, 10'd32);
    check_eq("t6_errclr", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd32));
    cyc(4);
    check_eq("t6_win1", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd32, 10'd64));
    pop = 1'b1;
    cyc(1);
    pop = 1'b0;
    check_eq("t6_err", obs(), pk(1'b0, 1'b1, 1'b0, 1'b1, 10'd32, 10'd64));
    #2 rst_n = 1'b0;
    #1 check_eq("t6_async", obs(), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    start_job(10'd0, 10'd100, 10'd32);
    check_eq("t6_restart", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd32));
    core_done = 6'h3F;
    cyc(2);
    check_eq("t6_done", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0));
    core_done = 6'd0;
    cyc(1);
    check_eq("t6_idle", obs(), 32'd0);

    // End of range with core 0 not done: wrap build returns to [0,32), default build finishes
    start_job(10'd0, 10'd64, 10'd32);
    core_done = 6'h3E;
    cyc(4);
    check_eq("t7_win1", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd32, 10'd64));
    cyc(3);
`ifdef POL_WS_WRAP_EN
    check_eq("t7_wrap", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd32));
    core_done = 6'h3F;
    cyc(1);
`endif
    check_eq("t7_done", obs(), pk(1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0));
    core_done = 6'd0;
    cyc(1);
    check_eq("t7_idle", obs(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
